// File: rtl/bus_cycle_scheduler.sv
// -----------------------------------------------------------------------------
// bus_cycle_scheduler
//
// Time-slot scheduler for the shared RAM/ROM bus. The bus alternates between
// 4-tick video slots and 4-tick CPU slots. Ticks are clk8_en_p strobes. The
// block grants whole slots to the 68000 and generates its DTACK. In turbo
// mode the CPU may also take a video slot that video/audio will not use.
//
// Parameters:
//   IO_LATENCY      clk8 ticks from I/O entry to DTACK (1..15)
//
// Ports:
//   clk             system clock
//   _reset          asynchronous active-low reset
//   clk8_en_p       tick strobe (rising 8 MHz phase); all scheduling uses it
//   clk8_en_n       falling-phase strobe; present for port symmetry only
//   _cpuAS          68000 address strobe, already synchronous to clk
//   selectRAM/ROM   memory decode
//   selectIO        I/O decode; any non-memory access is treated as I/O
//   videoNeedNext   next video slot carries loadPixels or loadSound
//   turbo           allow the CPU to take an unneeded video slot
//   videoBusControl current slot is a video slot
//   cpuBusControl   current slot is a CPU slot
//   cycleReady      pulse on the final tick of every slot
//   cpuMemGrant     CPU owns the memory bus in the current slot
//   busPhase        tick index within the slot, 0..3
//   _cpuDTACK       data transfer acknowledge, active low
// -----------------------------------------------------------------------------
module bus_cycle_scheduler #(
    parameter int unsigned IO_LATENCY = 3
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       clk8_en_p,
    input  logic       clk8_en_n,
    input  logic       _cpuAS,
    input  logic       selectRAM,
    input  logic       selectROM,
    input  logic       selectIO,
    input  logic       videoNeedNext,
    input  logic       turbo,
    output logic       videoBusControl,
    output logic       cpuBusControl,
    output logic       cycleReady,
    output logic       cpuMemGrant,
    output logic [1:0] busPhase,
    output logic       _cpuDTACK
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SLOT,
        ST_MEM,
        ST_IO,
        ST_ACK
    } state_e;

    localparam logic [3:0] IO_LOAD = 4'(IO_LATENCY);

    logic [1:0] phase_q, phase_d;
    logic       slot_q, slot_d;      // 0 = video slot, 1 = CPU slot
    state_e     state_q, state_d;
    logic [3:0] io_cnt_q, io_cnt_d;

    logic       cycle_ready;
    logic       next_slot_granted;
    logic       mem_select;

    // clk8_en_n needs no logic. Every non-memory access is handled as I/O, so
    // selectIO is not needed to pick the path either.
    logic unused_inputs;
    assign unused_inputs = clk8_en_n ^ selectIO;

    assign mem_select  = selectRAM | selectROM;
    assign cycle_ready = clk8_en_p && (phase_q == 2'd3);

    // The decision is made on the last tick of the current slot, for the slot
    // that starts next. A video slot now means a CPU slot follows, and a CPU
    // slot is always granted. A CPU slot now means a video slot follows. That
    // video slot is granted only when turbo is on and video does not need it.
    assign next_slot_granted = !slot_q || (turbo && !videoNeedNext);

    // -------------------------------------------------------------------------
    // Slot counter
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal this block drives gets a default first. No path
        // leaves a signal unassigned, so synthesis builds no latch.
        phase_d = phase_q;
        slot_d  = slot_q;
        if (clk8_en_p) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
                slot_d = ~slot_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // CPU access state machine
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        io_cnt_d = io_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                // A request is accepted only on a tick. A request that arrives
                // on the last tick of a slot waits for the next slot boundary.
                if (clk8_en_p && !_cpuAS) begin
                    if (mem_select) begin
                        state_d = ST_WAIT_SLOT;
                    end else begin
                        state_d  = ST_IO;
                        io_cnt_d = IO_LOAD;
                    end
                end
            end
            ST_WAIT_SLOT: begin
                if (_cpuAS) begin
                    state_d = ST_IDLE;
                end else if (cycle_ready && next_slot_granted) begin
                    state_d = ST_MEM;
                end
            end
            ST_MEM: begin
                // MEM is entered at a slot start. The next cycleReady is
                // therefore the end of that same slot.
                if (_cpuAS) begin
                    state_d = ST_IDLE;
                end else if (cycle_ready) begin
                    state_d = ST_ACK;
                end
            end
            ST_IO: begin
                if (_cpuAS) begin
                    state_d  = ST_IDLE;
                    io_cnt_d = 4'd0;
                end else if (clk8_en_p) begin
                    if (io_cnt_q <= 4'd1) begin
                        state_d  = ST_ACK;
                        io_cnt_d = 4'd0;
                    end else begin
                        io_cnt_d = io_cnt_q - 4'd1;
                    end
                end
            end
            ST_ACK: begin
                if (_cpuAS) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                io_cnt_d = 4'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            phase_q  <= 2'd0;
            slot_q   <= 1'b0;
            state_q  <= ST_IDLE;
            io_cnt_q <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every
            // register then samples the pre-edge values, whatever the
            // statement order.
            phase_q  <= phase_d;
            slot_q   <= slot_d;
            state_q  <= state_d;
            io_cnt_q <= io_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from registered state (cycleReady also uses the strobe)
    // -------------------------------------------------------------------------
    assign busPhase        = phase_q;
    assign videoBusControl = !slot_q;
    assign cpuBusControl   = slot_q;
    assign cycleReady      = cycle_ready;
    assign cpuMemGrant     = (state_q == ST_MEM);
    assign _cpuDTACK       = (state_q != ST_ACK);

endmodule

// File: tb/tb_bus_cycle_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bus_cycle_scheduler
//
// Directed bench for bus_cycle_scheduler. Each stimulus step pushes the events
// it expects onto a queue: grant rise/fall and DTACK fall/rise. Each entry
// holds the latency in clks from the _cpuAS edge and the slot/phase expected
// when the event appears. A monitor watches the DUT outputs on the falling
// clock edge and pops one entry for every edge it sees.
// clk8_en_p pulses once every 4 clks.
// -----------------------------------------------------------------------------
module tb_bus_cycle_scheduler;

    logic       clk           = 1'b0;
    logic       _reset        = 1'b1;
    logic       clk8_en_p     = 1'b0;
    logic       clk8_en_n     = 1'b0;
    logic       _cpuAS        = 1'b1;
    logic       selectRAM     = 1'b0;
    logic       selectROM     = 1'b0;
    logic       selectIO      = 1'b0;
    logic       videoNeedNext = 1'b0;
    logic       turbo         = 1'b0;
    logic       videoBusControl;
    logic       cpuBusControl;
    logic       cycleReady;
    logic       cpuMemGrant;
    logic [1:0] busPhase;
    logic       _cpuDTACK;

    bus_cycle_scheduler #(.IO_LATENCY(3)) dut (
        .clk            (clk),
        ._reset         (_reset),
        .clk8_en_p      (clk8_en_p),
        .clk8_en_n      (clk8_en_n),
        ._cpuAS         (_cpuAS),
        .selectRAM      (selectRAM),
        .selectROM      (selectROM),
        .selectIO       (selectIO),
        .videoNeedNext  (videoNeedNext),
        .turbo          (turbo),
        .videoBusControl(videoBusControl),
        .cpuBusControl  (cpuBusControl),
        .cycleReady     (cycleReady),
        .cpuMemGrant    (cpuMemGrant),
        .busPhase       (busPhase),
        ._cpuDTACK      (_cpuDTACK)
    );

    typedef enum int {EV_GRANT_RISE, EV_GRANT_FALL, EV_DTACK_FALL, EV_DTACK_RISE} ev_kind_e;

    typedef struct {
        ev_kind_e kind;
        int       lat;        // clks after the _cpuAS edge
        int       from_rise;  // 1: measured from _cpuAS rise, 0: from its fall
        int       vbc;        // expected videoBusControl
        int       phase;      // expected busPhase
    } ev_t;

    typedef struct {
        int vbc;
        int phase;
    } ph_t;

    ev_t   exp_q[$];
    ph_t   ph_q[$];
    int    checks      = 0;
    int    errors      = 0;
    int    cyc         = 0;
    int    tk          = 0;    // ticks since reset release
    logic  en_edge     = 1'b0; // last posedge was a tick
    int    as_fall_cyc = 0;
    int    as_rise_cyc = 0;
    int    cr_count    = 0;
    string test_name   = "reset";

    always #5 clk = ~clk;

    // Tick generator and bench-side tick model: phase = tk%4, cpu slot = (tk/4)%2
    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            cyc++;
            en_edge = clk8_en_p && _reset;
            if (!_reset) tk = 0;
            else if (clk8_en_p) tk++;
            #1;
            div = (div + 1) % 4;
            clk8_en_p = (div == 0);
            clk8_en_n = (div == 2);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d required %0d", test_name, name, act, exp);
        end
    endtask

    task automatic score(input ev_kind_e kind);
        ev_t e;
        int  lat;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s/unexpected_%s: seen at cycle %0d, required no event",
                     test_name, kind.name(), cyc);
        end else begin
            e   = exp_q.pop_front();
            lat = (e.from_rise != 0) ? cyc - as_rise_cyc : cyc - as_fall_cyc;
            check({"kind_", e.kind.name()}, 32'(kind), 32'(e.kind));
            check({"lat_", e.kind.name()}, lat, e.lat);
            check({"vbc_", e.kind.name()}, 32'(videoBusControl), e.vbc);
            check({"phase_", e.kind.name()}, 32'(busPhase), e.phase);
        end
    endtask

    // Monitor
    initial begin
        logic g_prev;
        logic d_prev;
        ph_t  pe;
        g_prev = 1'b0;
        d_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!_reset) begin
                g_prev = cpuMemGrant;
                d_prev = _cpuDTACK;
                continue;
            end
            if (cycleReady) cr_count++;
            if (en_edge && ph_q.size() > 0) begin
                pe = ph_q.pop_front();
                check("busPhase", 32'(busPhase), pe.phase);
                check("videoBusControl", 32'(videoBusControl), pe.vbc);
                check("cpuBusControl", 32'(cpuBusControl), 32'(pe.vbc == 0));
            end
            if (cpuMemGrant && !g_prev) score(EV_GRANT_RISE);
            if (!cpuMemGrant && g_prev) score(EV_GRANT_FALL);
            if (!_cpuDTACK && d_prev)   score(EV_DTACK_FALL);
            if (_cpuDTACK && !d_prev)   score(EV_DTACK_RISE);
            g_prev = cpuMemGrant;
            d_prev = _cpuDTACK;
        end
    end

    task automatic expect_ev(input ev_kind_e kind, input int lat, input int from_rise,
                             input int vbc, input int phase);
        ev_t e;
        e.kind = kind; e.lat = lat; e.from_rise = from_rise; e.vbc = vbc; e.phase = phase;
        exp_q.push_back(e);
    endtask

    // Returns just after the tick that leaves the DUT at (slot, phase).
    task automatic wait_at(input int slot_cpu, input int phase);
        int budget;
        budget = 0;
        do begin
            @(posedge clk); #2;
            budget++;
        end while (!(en_edge && (tk % 4) == phase && ((tk / 4) % 2) == slot_cpu) && budget < 200);
        if (budget >= 200) begin
            checks++; errors++;
            $display("FAIL %s/wait_slot_phase: got timeout required slot %0d phase %0d",
                     test_name, slot_cpu, phase);
        end
    endtask

    task automatic wait_dtack();
        int budget;
        budget = 0;
        do begin
            @(posedge clk); #2;
            budget++;
        end while (_cpuDTACK !== 1'b0 && budget < 200);
        if (budget >= 200) begin
            checks++; errors++;
            $display("FAIL %s/dtack_timeout: got 1 required 0", test_name);
        end
    endtask

    task automatic start_access(input logic ram, input logic rom, input logic io);
        selectRAM = ram; selectROM = rom; selectIO = io;
        _cpuAS = 1'b0;
        as_fall_cyc = cyc;
    endtask

    task automatic release_as();
        _cpuAS = 1'b1;
        selectRAM = 1'b0; selectROM = 1'b0; selectIO = 1'b0;
        as_rise_cyc = cyc;
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        ph_t p;
        #1 _reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busPhase", 32'(busPhase), 0);
        check("rst_videoBusControl", 32'(videoBusControl), 1);
        check("rst_cpuBusControl", 32'(cpuBusControl), 0);
        check("rst_cycleReady", 32'(cycleReady), 0);
        check("rst_cpuMemGrant", 32'(cpuMemGrant), 0);
        check("rst_cpuDTACK", 32'(_cpuDTACK), 1);

        // Free run: 16 ticks
        test_name = "free_run";
        for (int k = 1; k <= 16; k++) begin
            p.phase = k % 4;
            p.vbc   = ((k / 4) % 2 == 0) ? 1 : 0;
            ph_q.push_back(p);
        end
        cr_count = 0;
        _reset = 1'b1;
        for (int i = 0; i < 200 && tk < 16; i++) begin
            @(posedge clk); #2;
        end
        check("cycleReady_pulses", cr_count, 4);
        check("tick_count", tk, 16);

        // RAM read from video tick 1, no turbo: CPU slot granted
        test_name = "ram_read";
        turbo = 1'b0; videoNeedNext = 1'b0;
        wait_at(0, 1);
        start_access(1'b1, 1'b0, 1'b0);
        expect_ev(EV_GRANT_RISE, 12, 0, 0, 0);
        expect_ev(EV_GRANT_FALL, 28, 0, 1, 0);
        expect_ev(EV_DTACK_FALL, 28, 0, 1, 0);
        wait_dtack();
        expect_ev(EV_DTACK_RISE, 1, 1, 1, 0);
        release_as();

        // Turbo: the unneeded video slot goes to the CPU
        test_name = "turbo_take";
        turbo = 1'b1; videoNeedNext = 1'b0;
        wait_at(1, 1);
        start_access(1'b1, 1'b0, 1'b0);
        expect_ev(EV_GRANT_RISE, 12, 0, 1, 0);
        expect_ev(EV_GRANT_FALL, 28, 0, 0, 0);
        expect_ev(EV_DTACK_FALL, 28, 0, 0, 0);
        wait_dtack();
        expect_ev(EV_DTACK_RISE, 1, 1, 0, 0);
        release_as();

        // Turbo, but video needs the slot: deferred to the next CPU slot
        test_name = "turbo_defer";
        videoNeedNext = 1'b1;
        wait_at(1, 1);
        start_access(1'b0, 1'b1, 1'b0);
        expect_ev(EV_GRANT_RISE, 28, 0, 0, 0);
        expect_ev(EV_GRANT_FALL, 44, 0, 1, 0);
        expect_ev(EV_DTACK_FALL, 44, 0, 1, 0);
        wait_dtack();
        expect_ev(EV_DTACK_RISE, 1, 1, 1, 0);
        release_as();
        turbo = 1'b0; videoNeedNext = 1'b0;

        // I/O from CPU tick 2: enters at cpu/3, DTACK 3 ticks later at video/2
        test_name = "io_select";
        wait_at(1, 2);
        start_access(1'b0, 1'b0, 1'b1);
        expect_ev(EV_DTACK_FALL, 16, 0, 1, 2);
        wait_dtack();
        expect_ev(EV_DTACK_RISE, 1, 1, 1, 2);
        release_as();

        // Unmapped access from video tick 0: I/O path that crosses into the CPU slot
        test_name = "io_unmapped";
        wait_at(0, 0);
        start_access(1'b0, 1'b0, 1'b0);
        expect_ev(EV_DTACK_FALL, 16, 0, 0, 0);
        wait_dtack();
        expect_ev(EV_DTACK_RISE, 1, 1, 0, 0);
        release_as();

        // Abort mid-MEM at CPU tick 2: grant drops next clk, no DTACK
        test_name = "abort_mem";
        wait_at(0, 1);
        start_access(1'b1, 1'b0, 1'b0);
        expect_ev(EV_GRANT_RISE, 12, 0, 0, 0);
        wait_at(1, 2);
        expect_ev(EV_GRANT_FALL, 1, 1, 0, 2);
        release_as();
        idle_clks(32);
        check("dtack_stays_high", 32'(_cpuDTACK), 1);
        check("events_consumed", exp_q.size(), 0);

        // Asynchronous reset while in ACK
        test_name = "reset_in_ack";
        wait_at(0, 1);
        start_access(1'b1, 1'b0, 1'b0);
        expect_ev(EV_GRANT_RISE, 12, 0, 0, 0);
        expect_ev(EV_GRANT_FALL, 28, 0, 1, 0);
        expect_ev(EV_DTACK_FALL, 28, 0, 1, 0);
        wait_dtack();
        @(posedge clk); #2;
        check("dtack_low_before_reset", 32'(_cpuDTACK), 0);
        _reset = 1'b0;
        #1;
        check("async_cpuDTACK", 32'(_cpuDTACK), 1);
        check("async_videoBusControl", 32'(videoBusControl), 1);
        check("async_cpuBusControl", 32'(cpuBusControl), 0);
        check("async_busPhase", 32'(busPhase), 0);
        check("async_cpuMemGrant", 32'(cpuMemGrant), 0);
        release_as();
        idle_clks(3);
        _reset = 1'b1;
        idle_clks(8);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bus_cycle_scheduler.md
# bus_cycle_scheduler

Time-slot scheduler for the shared RAM/ROM bus. It splits the bus into alternating 4-tick video and CPU slots, counted in clk8 ticks, and drives the bus-control signals that the address controller consumes: `videoBusControl`, `cpuBusControl` and `cycleReady`. It grants whole slots to the 68000 and generates `_cpuDTACK`. An optional turbo mode lets the CPU take a video slot that the video and audio engines will not use.

## Interface
Parameters:
- `IO_LATENCY`, 3: clk8 ticks from the start of an I/O access until DTACK. Range 1..15.

Ports:
- `clk`  in  1  system clock
- `_reset`  in  1  asynchronous, active-low reset
- `clk8_en_p`  in  1  one-clk strobe, rising edge of the 8 MHz phase; all scheduling advances on it
- `clk8_en_n`  in  1  one-clk strobe, falling edge of the 8 MHz phase; unused internally, kept for port symmetry
- `_cpuAS`  in  1  68000 address strobe, already synchronous to `clk`
- `selectRAM`, `selectROM`  in  1 each  memory decode from the address decoder
- `selectIO`  in  1  OR of selectVIA/SCC/IWM/SCSI/SEOverlay
- `videoNeedNext`  in  1  the next video slot will carry loadPixels or loadSound
- `turbo`  in  1  allow the CPU to take an unneeded video slot
- `videoBusControl`  out  1  current slot is a video slot
- `cpuBusControl`  out  1  current slot is a CPU slot
- `cycleReady`  out  1  one-clk pulse on the final tick of every slot
- `cpuMemGrant`  out  1  CPU owns the memory bus in the current slot; gates RAM/ROM strobes
- `busPhase`  out  2  tick index within the slot, 0..3
- `_cpuDTACK`  out  1  data transfer acknowledge to the 68000, active low

## Operation
Slot counter:
- `busPhase` increments on each `clk8_en_p` and wraps 3→0.
- Internal `slot` toggles on each wrap: 0 = video slot, 1 = CPU slot.
- `videoBusControl = !slot`, `cpuBusControl = slot`.
- `cycleReady = clk8_en_p && busPhase==3`. It is a combinational pulse from registered state.

CPU state machine (states IDLE, WAIT_SLOT, MEM, IO, ACK):
- IDLE → WAIT_SLOT: on `clk8_en_p` with `_cpuAS`=0 and (`selectRAM` | `selectROM`).
- IDLE → IO: on `clk8_en_p` with `_cpuAS`=0, no memory select. Unmapped addresses also take IO. Loads `ioCnt` = `IO_LATENCY`.
- WAIT_SLOT → MEM at a `cycleReady` when the slot about to start is granted. A slot is granted if:
  - it is a CPU slot; or
  - it is a video slot and `turbo`=1 and `videoNeedNext`=0.
- MEM: `cpuMemGrant`=1 for the whole slot, ticks 0..3. At the slot's `cycleReady`, go to ACK.
- IO: `ioCnt` decrements on each `clk8_en_p`. On reaching 0, go to ACK.
- ACK: `_cpuDTACK`=0 and held until `_cpuAS`=1. When `_cpuAS` rises, return to IDLE on the next `clk` and `_cpuDTACK`=1.
- `_cpuAS` released in WAIT_SLOT, MEM or IO (aborted cycle): go to IDLE on the next `clk`. No DTACK is issued. `cpuMemGrant` drops at once.
- The CPU never holds a slot across a slot boundary. A new access always waits for the next slot start.

## Timing
- Reset values: `busPhase`=0, `slot`=0 (video), `videoBusControl`=1, `cpuBusControl`=0, `cycleReady`=0, `cpuMemGrant`=0, `_cpuDTACK`=1, state IDLE, `ioCnt`=0.
- All registers update only on `clk`. Apart from `_cpuAS` release and ACK exit, state changes happen only on `clk` edges where `clk8_en_p`=1.
- Grant decision: `videoNeedNext` and `turbo` are sampled on the `cycleReady` clk.
- `cpuMemGrant` asserts on the first `clk` after that `cycleReady` and lasts 4 ticks.
- Memory latency: DTACK asserts on the `clk` after the `cycleReady` that ends the MEM slot. Worst case from AS is 1 + 4 + 4 + 4 = 13 ticks: up to 1 tick to detect AS, up to 4 ticks to the next slot start, a refused video slot, then the 4-tick CPU slot.
- I/O latency: exactly `IO_LATENCY` ticks from entering IO, independent of slots.
- Request detected on the same tick as `cycleReady`: IDLE→WAIT_SLOT first; the grant waits for the next `cycleReady`.
- Asynchronous reset mid-access: all outputs return to reset values immediately and the slot phase restarts at video/0.

## Test plan
- Free run, no CPU activity, 16 `clk8_en_p` after reset:
  - `busPhase` 0,1,2,3 repeating; `slot` video,cpu,video,cpu.
  - `cycleReady` pulses exactly 4 times.
- RAM read, `_cpuAS` falls at video tick 1, `turbo`=0:
  - `cpuMemGrant` high for CPU ticks 0..3.
  - `_cpuDTACK`=0 one clk after that slot's `cycleReady`; releases one clk after `_cpuAS`=1.
- `turbo`=1, `videoNeedNext`=0, request pending at end of a CPU slot:
  - next video slot granted; `cpuMemGrant`=1 while `videoBusControl`=1.
  - repeat with `videoNeedNext`=1: grant deferred to the following CPU slot.
- I/O access with `IO_LATENCY`=3, `selectIO`=1: `_cpuDTACK` low exactly 3 ticks after IO entry, regardless of slot.
- Abort and reset:
  - `_cpuAS` released mid-MEM at tick 2: `cpuMemGrant`=0 next clk, no DTACK pulse.
  - separately, `_reset` asserted during ACK: `_cpuDTACK`=1 and `videoBusControl`=1 asynchronously.
